// File: rtl/regfile_wdecode_pkg.sv
// Shared constants for the MIPS register file, control unit and destination-select mux.
package regfile_wdecode_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wdecode_if.sv
// Write-back, read and display signals of the register file, grouped for the CPU datapath.
interface regfile_wdecode_if
  import regfile_wdecode_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);

  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra1;
  logic [DW-1:0] rd1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd2;
  logic [AW-1:0] dbg_a;
  logic [DW-1:0] dbg_d;
  logic          wr_hit;
  logic [CNT_W-1:0] wr_cnt;

  modport master (
    output we, wa, wd, ra1, ra2, dbg_a,
    input  rd1, rd2, dbg_d, wr_hit, wr_cnt
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, dbg_a,
    output rd1, rd2, dbg_d, wr_hit, wr_cnt
  );

endinterface

// File: rtl/regfile_wdecode_decoder_5to32.sv
// Binary-to-one-hot decoder; y is all zero while en is low, whatever a holds.
module decoder_5to32 #(
  parameter int A_W = 5
) (
  input  logic [A_W-1:0]      a,
  input  logic                en,
  output logic [(2**A_W)-1:0] y
);

  localparam int N = 2**A_W;

  assign y = en ? (N'(1) << a) : '0;

endmodule

// File: rtl/regfile_wdecode.sv
// 32-entry MIPS register file: one-hot write decode, two async read ports, debug port, write counter.
module regfile_wdecode
  import regfile_wdecode_pkg::*;
#(
  parameter int DATA_W = regfile_wdecode_pkg::DATA_W,
  parameter int ADDR_W = regfile_wdecode_pkg::ADDR_W,
  parameter int BYPASS = 0
) (
  input  logic clk,
  input  logic rst,
  regfile_wdecode_if.slave bus
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0]   dec_y;
  logic [NREG-1:0]   wen;
  logic [DATA_W-1:0] regs_q [NREG];
  logic              commit;
  logic              wr_hit_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [DATA_W-1:0] rd1_c, rd2_c, dbg_c;

  decoder_5to32 #(.A_W(ADDR_W)) u_dec (
    .a  (bus.wa),
    .en (bus.we),
    .y  (dec_y)
  );

  // $0 is hard-wired: its enable is masked so the storage never changes
  assign wen    = dec_y & ~NREG'(1);
  assign commit = bus.we && (bus.wa != ADDR_W'(REG_ZERO));

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        regs_q[gi] <= '0;
      else if (wen[gi])
        regs_q[gi] <= bus.wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_hit_q <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      wr_hit_q <= commit;
      if (commit)
        wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  // Forwarding is suppressed under reset so every port reads 0 while rst is high
  always_comb begin
    rd1_c = (bus.ra1 == '0) ? '0 : regs_q[bus.ra1];
    rd2_c = (bus.ra2 == '0) ? '0 : regs_q[bus.ra2];
    dbg_c = (bus.dbg_a == '0) ? '0 : regs_q[bus.dbg_a];
    if (BYPASS != 0 && !rst && commit) begin
      if (bus.ra1 == bus.wa) rd1_c = bus.wd;
      if (bus.ra2 == bus.wa) rd2_c = bus.wd;
    end
  end

  assign bus.rd1    = rd1_c;
  assign bus.rd2    = rd2_c;
  assign bus.dbg_d  = dbg_c;
  assign bus.wr_hit = wr_hit_q;
  assign bus.wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regfile_wdecode.sv
// Scoreboard bench: two register files (no forwarding / forwarding) driven with identical vectors.
module tb_regfile_wdecode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [4:0]  dbg_a = '0;

  always #5 clk = ~clk;

  regfile_wdecode_if #(.DW(32), .AW(5)) if0 ();
  regfile_wdecode_if #(.DW(32), .AW(5)) if1 ();

  assign if0.we = we;   assign if1.we = we;
  assign if0.wa = wa;   assign if1.wa = wa;
  assign if0.wd = wd;   assign if1.wd = wd;
  assign if0.ra1 = ra1; assign if1.ra1 = ra1;
  assign if0.ra2 = ra2; assign if1.ra2 = ra2;
  assign if0.dbg_a = dbg_a; assign if1.dbg_a = dbg_a;

  regfile_wdecode #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  regfile_wdecode #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam int S_RD1 = 0, S_RD2 = 1, S_DBG = 2, S_HIT = 3, S_CNT = 4;
  localparam int S_RD1_B = 5, S_RD2_B = 6, S_DBG_B = 7;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_RD1:   return if0.rd1;
      S_RD2:   return if0.rd2;
      S_DBG:   return if0.dbg_d;
      S_HIT:   return {31'b0, if0.wr_hit};
      S_CNT:   return {16'b0, if0.wr_cnt};
      S_RD1_B: return if1.rd1;
      S_RD2_B: return if1.rd2;
      S_DBG_B: return if1.dbg_d;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Inputs change just after posedge; the monitor samples mid-cycle on negedge
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    sync();
    we = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      got = probe(e.sel);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got=%08h expected=%08h", e.tag, got, e.exp);
      end else begin
        $display("ok   %s: %08h", e.tag, got);
      end
    end
  end

  initial begin
    // 1: reset, then every address reads 0 on all ports
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_val(S_HIT, 32'd0, "reset_hit");
    expect_val(S_CNT, 32'd0, "reset_cnt");
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(a); dbg_a = 5'(a);
      expect_val(S_RD1, 32'd0, $sformatf("reset_rd1[%0d]", a));
      expect_val(S_RD2, 32'd0, $sformatf("reset_rd2[%0d]", a));
      expect_val(S_DBG, 32'd0, $sformatf("reset_dbg[%0d]", a));
      sync();
    end

    // 2: write reg 8, neighbours untouched, one-cycle wr_hit
    do_write(5'd8, 32'hDEADBEEF);
    ra1 = 5'd8; ra2 = 5'd7; dbg_a = 5'd9;
    expect_val(S_RD1, 32'hDEADBEEF, "w8_rd1");
    expect_val(S_RD2, 32'd0, "w8_reg7");
    expect_val(S_DBG, 32'd0, "w8_reg9");
    expect_val(S_HIT, 32'd1, "w8_hit");
    expect_val(S_CNT, 32'd1, "w8_cnt");
    sync();
    expect_val(S_HIT, 32'd0, "w8_hit_drop");
    expect_val(S_CNT, 32'd1, "w8_cnt_hold");
    sync();

    // 3: write to $0 is discarded and not counted
    do_write(5'd0, 32'hFFFFFFFF);
    ra1 = 5'd0; dbg_a = 5'd0;
    expect_val(S_RD1, 32'd0, "w0_rd1");
    expect_val(S_DBG, 32'd0, "w0_dbg");
    expect_val(S_HIT, 32'd0, "w0_hit");
    expect_val(S_CNT, 32'd1, "w0_cnt");
    sync();

    // 4: same-cycle read of the register being written
    do_write(5'd5, 32'h11);
    we = 1'b1; wa = 5'd5; wd = 32'h22;
    ra1 = 5'd5; ra2 = 5'd5; dbg_a = 5'd5;
    expect_val(S_RD1, 32'h11, "nobyp_rd1_pre");
    expect_val(S_RD2, 32'h11, "nobyp_rd2_pre");
    expect_val(S_RD1_B, 32'h22, "byp_rd1_pre");
    expect_val(S_RD2_B, 32'h22, "byp_rd2_pre");
    expect_val(S_DBG_B, 32'h11, "byp_dbg_pre");
    sync();
    we = 1'b0;
    expect_val(S_RD1, 32'h22, "nobyp_rd1_post");
    expect_val(S_RD2, 32'h22, "nobyp_rd2_post");
    expect_val(S_RD1_B, 32'h22, "byp_rd1_post");
    expect_val(S_CNT, 32'd3, "byp_cnt");
    sync();
    we = 1'b1; wa = 5'd0; wd = 32'h0000AAAA; ra1 = 5'd0;
    expect_val(S_RD1_B, 32'd0, "byp_r0");
    sync();
    we = 1'b0;
    expect_val(S_CNT, 32'd3, "byp_r0_cnt");
    sync();

    // 5: async reset between edges while a write to $ra is pending
    do_write(5'd31, 32'h1234);
    ra1 = 5'd31; ra2 = 5'd31;
    expect_val(S_RD1, 32'h1234, "w31_rd1");
    expect_val(S_CNT, 32'd4, "w31_cnt");
    sync();
    we = 1'b1; wa = 5'd31; wd = 32'h5555;
    #2;
    rst = 1'b1;
    expect_val(S_RD1, 32'd0, "arst_rd1");
    expect_val(S_RD2_B, 32'd0, "arst_byp_rd2");
    expect_val(S_CNT, 32'd0, "arst_cnt");
    expect_val(S_HIT, 32'd0, "arst_hit");
    sync();
    we = 1'b0;
    sync();
    rst = 1'b0;
    expect_val(S_RD1, 32'd0, "arst_rel_rd1");
    expect_val(S_HIT, 32'd0, "arst_rel_hit");
    expect_val(S_CNT, 32'd0, "arst_rel_cnt");
    sync();

    // 6: wr_cnt wraps after 65536 commits
    we = 1'b1; wa = 5'd3; ra1 = 5'd3;
    for (int i = 1; i <= 65535; i++) begin
      wd = 32'(i);
      sync();
    end
    wd = 32'hCAFE0000;
    expect_val(S_CNT, 32'h0000FFFF, "wrap_cnt_ffff");
    expect_val(S_RD1, 32'h0000FFFF, "wrap_rd1_old");
    expect_val(S_RD1_B, 32'hCAFE0000, "wrap_byp_new");
    sync();
    we = 1'b0;
    expect_val(S_CNT, 32'd0, "wrap_cnt_zero");
    expect_val(S_RD1, 32'hCAFE0000, "wrap_reg3");
    expect_val(S_HIT, 32'd1, "wrap_hit");
    sync();

    // Unknown write address while we is low must not disturb anything
    wa = 5'bxxxxx;
    sync();
    wa = 5'd3;
    expect_val(S_RD1, 32'hCAFE0000, "xwa_reg3");
    expect_val(S_CNT, 32'd0, "xwa_cnt");
    expect_val(S_HIT, 32'd0, "xwa_hit");
    sync();
    sync();

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got=%0d pending expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wdecode.md
Name: regfile_wdecode

Overview:
- 32-entry MIPS general register file for the multi-cycle CPU; sits downstream of the 5-bit write-destination select (rt/rd/$ra).
- Decodes the selected 5-bit destination into 32 one-hot write enables and commits the write-back value on the clock edge.
- Provides two asynchronous read ports for ID/EX and one debug read port for the board display.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.
- BYPASS, 0, 1 = a read of the address being written returns wd in the same cycle; 0 = no forwarding.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable from the control FSM (WB state).
- wa  in  ADDR_W  write address, from the destination-select mux.
- wd  in  DATA_W  write data (ALUOut / MDR / PC+4).
- ra1  in  ADDR_W  read address A (rs).
- rd1  out  DATA_W  read data A.
- ra2  in  ADDR_W  read address B (rt).
- rd2  out  DATA_W  read data B.
- dbg_a  in  ADDR_W  debug read address.
- dbg_d  out  DATA_W  debug read data.
- wr_hit  out  1  registered pulse: a write committed on the previous edge.
- wr_cnt  out  16  count of committed writes, for the display.

Behaviour:
Reset:
- rst high clears all 32 registers to 0 immediately, without waiting for clk.
- Reset also clears wr_hit and wr_cnt to 0.
- If rst asserts during a cycle with we=1, the write is lost and the register stays 0.
- Reads are combinational, so rd1, rd2 and dbg_d show 0 while rst is high.

Write decode:
- wen[i] = we & (wa==i) for i = 1..31.
- wen[0] is permanently 0.

Write:
- On posedge clk with rst low, every register with wen[i]=1 loads wd.
- At most one enable is ever active.
- Write latency is 1 edge.

$0:
- Always reads 0 on every port.
- A write to address 0 is discarded and does not count as a write.

Read:
- rdN = (raN==0) ? 0 : reg[raN].
- Reads are combinational, with zero latency.
- BYPASS=0: in the cycle of a write, the read returns the old value; the new value is visible after the edge.
- BYPASS=1: if we & wa!=0 & raN==wa, rdN = wd. The debug port is never bypassed.

wr_hit:
- Next state = we & (wa!=0).
- High for exactly one cycle after each committed write.

wr_cnt:
- Increments on each committed write.
- Wraps from 0xFFFF to 0x0000 without saturating.

Other boundaries:
- Both read ports may address the same register, including wa; both return identical data.
- An X/Z value on wa while we=0 has no effect.

Decomposition:
- Shared include header: `define REG_ZERO 5'd0, `define REG_RA 5'd31, `define DATA_W 32, `define ADDR_W 5. Reused by the control unit and the destination mux.
- One sub-module, decoder_5to32: input [4:0] a, input en, output [31:0] y, with y = en << a. The register file masks bit 0.
- Storage, read muxes and counters stay in regfile_wdecode.

Test Plan:
1. rst=1 for 2 cycles, then release -> rd1=rd2=dbg_d=0 for every address 0..31; wr_cnt=0; wr_hit=0.
2. we=1, wa=8, wd=0xDEADBEEF for one edge, then ra1=8 -> rd1=0xDEADBEEF; wr_hit=1 for one cycle; wr_cnt=1. Registers 7 and 9 still read 0.
3. we=1, wa=0, wd=0xFFFFFFFF -> rd1 with ra1=0 reads 0; wr_hit stays 0; wr_cnt unchanged.
4. BYPASS=0, reg[5]=0x11, then write wa=5, wd=0x22 with ra1=ra2=5 -> both ports read 0x11 before the edge and 0x22 after it. With BYPASS=1, both ports read 0x22 in the same cycle.
5. Write 0x1234 to reg 31, then assert rst asynchronously between edges while we=1, wa=31 -> reg 31 reads 0 immediately and after release; no write lands.
6. Preload wr_cnt to 0xFFFF via 65535 writes to wa=3, then one more write -> wr_cnt=0x0000; reg 3 holds the last wd.
